// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply (shift-add) / divide (restoring) unit producing HI/LO.
// Define MULDIV_UNSIGNED_EN to add the is_unsigned input for multu/divu.
module mul_div_unit #(
  parameter int unsigned WIDTH     = 32,
  parameter logic [3:0]  MULT_CODE = 4'b0101,
  parameter logic [3:0]  DIV_CODE  = 4'b1011
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       ALU_Control,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef MULDIV_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 op_div_q, op_div_d;
  logic                 bzero_q, bzero_d;
  logic                 neg_lo_q, neg_lo_d;
  logic                 neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;

  logic                 signed_op;
  logic                 valid_code;
  logic                 is_div;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift;
  logic                 div_borrow;
  logic [WIDTH-1:0]     div_rem;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   mul_fix;
  logic [WIDTH-1:0]     div_q_fix, div_r_fix;

`ifdef MULDIV_UNSIGNED_EN
  assign signed_op = ~is_unsigned;
`else
  assign signed_op = 1'b1;
`endif

  assign valid_code = (ALU_Control == MULT_CODE) || (ALU_Control == DIV_CODE);
  assign is_div     = (ALU_Control == DIV_CODE);
  assign a_mag      = (signed_op && A[WIDTH-1]) ? -A : A;
  assign b_mag      = (signed_op && B[WIDTH-1]) ? -B : B;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}; quotient bits shift in from the right.
  // A divisor of zero never borrows, leaving |A| as remainder and all-ones quotient.
  assign div_shift  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_borrow = div_shift < {1'b0, opnd_q};
  assign div_rem    = div_shift[WIDTH-1:0] - opnd_q;
  assign div_next   = div_borrow ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                 : {div_rem, acc_q[WIDTH-2:0], 1'b1};

  assign mul_fix   = neg_lo_q ? -acc_q : acc_q;
  assign div_q_fix = bzero_q ? '1 : (neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
  assign div_r_fix = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_div_d = op_div_q;
    bzero_d  = bzero_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && valid_code) begin
          op_div_d = is_div;
          bzero_d  = (B == '0);
          neg_lo_d = signed_op && (A[WIDTH-1] ^ B[WIDTH-1]);
          neg_hi_d = signed_op && A[WIDTH-1];
          opnd_d   = is_div ? b_mag : a_mag;
          acc_d    = {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        acc_d = op_div_q ? div_next : mul_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        if (op_div_q) begin
          hi_d = div_r_fix;
          lo_d = div_q_fix;
        end else begin
          hi_d = mul_fix[2*WIDTH-1:WIDTH];
          lo_d = mul_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        dbz_d   = op_div_q && bzero_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_div_q <= 1'b0;
      bzero_q  <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_div_q <= op_div_d;
      bzero_q  <= bzero_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign HI          = hi_q;
  assign LO          = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed + scoreboard bench for mul_div_unit (signed build, WIDTH=32).
module tb_mul_div_unit;

  localparam logic [3:0] MULT = 4'b0101;
  localparam logic [3:0] DIV  = 4'b1011;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  alu_ctrl;
  logic [31:0] a, b;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(32), .MULT_CODE(4'b0101), .DIV_CODE(4'b1011)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .ALU_Control (alu_ctrl),
    .A           (a),
    .B           (b),
`ifdef MULDIV_UNSIGNED_EN
    .is_unsigned (1'b0),
`endif
    .busy        (busy),
    .done        (done),
    .div_by_zero (dbz),
    .HI          (hi),
    .LO          (lo)
  );

  typedef struct packed {
    logic        dbz;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        last_e;
  int unsigned pass_cnt = 0;
  int unsigned fail_cnt = 0;
  int unsigned total_cnt = 0;

  function automatic exp_t model(input logic [3:0] code, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    longint      sx, sy, p, q, r;
    logic [63:0] pv, qv, rv;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e  = '0;
    if (code == MULT) begin
      p  = sx * sy;
      pv = p;
      e.hi = pv[63:32];
      e.lo = pv[31:0];
    end else if (y == 32'h0) begin
      e.dbz = 1'b1;
      e.hi  = x;
      e.lo  = 32'hFFFF_FFFF;
    end else begin
      q  = sx / sy;
      r  = sx % sy;
      qv = q;
      rv = r;
      e.hi = rv[31:0];
      e.lo = qv[31:0];
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; start is held for exactly one rising edge.
  task automatic issue(input logic [3:0] code, input logic [31:0] x, input logic [31:0] y);
    alu_ctrl = code;
    a        = x;
    b        = y;
    start    = 1'b1;
    sb_q.push_back(model(code, x, y));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the negedge where done is high.
  task automatic wait_result(input string tag, input int inject_at);
    int   cycles;
    int   busy_cnt;
    exp_t e;
    cycles   = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && cycles < 100) begin
      if (busy === 1'b1) busy_cnt++;
      if (cycles == inject_at) begin
        alu_ctrl = DIV;
        a        = 32'd55;
        b        = 32'd0;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      cycles++;
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(cycles), 64'd33);
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "_sb_nonempty"}, 64'(sb_q.size() != 0), 64'd1);
    e = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
    last_e = e;
    check({tag, "_HI"}, 64'(hi), 64'(e.hi));
    check({tag, "_LO"}, 64'(lo), 64'(e.lo));
    check({tag, "_dbz"}, 64'(dbz), 64'(e.dbz));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  rc;
    logic [31:0] ra, rb;
    reset_n  = 1'b0;
    start    = 1'b0;
    alu_ctrl = 4'h0;
    a        = '0;
    b        = '0;
    last_e   = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dbz", 64'(dbz), 64'd0);
    check("rst_HI", 64'(hi), 64'd0);
    check("rst_LO", 64'(lo), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    issue(MULT, 32'd7, 32'd6);
    wait_result("mul_7x6", -1);
    check("mul_7x6_LO_const", 64'(lo), 64'h2A);
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);

    issue(MULT, 32'hFFFF_FFFD, 32'd5);
    wait_result("mul_m3x5", -1);
    check("mul_m3x5_HI_const", 64'(hi), 64'hFFFF_FFFF);
    @(negedge clk);
    issue(MULT, 32'h8000_0000, 32'h8000_0000);
    wait_result("mul_min_sq", -1);
    check("mul_min_sq_HI_const", 64'(hi), 64'h4000_0000);
    @(negedge clk);
    issue(DIV, 32'hFFFF_FFF9, 32'd2);
    wait_result("div_m7_2", -1);
    check("div_m7_2_LO_const", 64'(lo), 64'hFFFF_FFFD);
    @(negedge clk);
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_result("div_min_m1", -1);
    check("div_min_m1_LO_const", 64'(lo), 64'h8000_0000);
    @(negedge clk);

    issue(DIV, 32'd100, 32'd0);
    wait_result("div_by0", -1);
    @(negedge clk);
    check("div_by0_done_pulse", 64'(done), 64'd0);
    check("div_by0_dbz_pulse", 64'(dbz), 64'd0);
    check("div_by0_HI_hold", 64'(hi), 64'd100);

    issue(DIV, 32'hFFFF_FF9C, 32'd0);
    wait_result("div_neg_by0", -1);
    @(negedge clk);

    issue(MULT, 32'h1234_5678, 32'hFEDC_BA98);
    wait_result("mul_inject", 10);
    @(negedge clk);

    alu_ctrl = 4'b0010;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("bad_code_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    check("bad_code_busy_late", 64'(busy), 64'd0);
    check("bad_code_done", 64'(done), 64'd0);
    check("bad_code_HI_hold", 64'(hi), 64'(last_e.hi));
    check("bad_code_LO_hold", 64'(lo), 64'(last_e.lo));

    issue(DIV, 32'd1000, 32'd7);
    repeat (14) @(negedge clk);
    check("abort_busy_before", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_HI", 64'(hi), 64'd0);
    check("abort_LO", 64'(lo), 64'd0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("abort_idle_after", 64'(busy), 64'd0);

    issue(MULT, 32'd3, 32'd3);
    wait_result("mul_3x3", -1);
    check("mul_3x3_LO_const", 64'(lo), 64'd9);

    // Each new request is presented on the done cycle of the previous one.
    for (int i = 0; i < 6; i++) begin
      rc = ($urandom_range(0, 1) == 0) ? MULT : DIV;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      if (i == 1) rb = 32'hFFFF_FFFF;
      issue(rc, ra, rb);
      wait_result("rand_b2b", -1);
    end
    @(negedge clk);
    check("final_done_low", 64'(done), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
